// File: rtl/mipi_rx_lane_deskew.sv
`default_nettype none
// ============================================================================
// Module      : mipi_rx_lane_deskew
// Description : Multi-lane CSI-2 byte deskew. Measures each active lane's
//               arrival offset at burst start, then delays early lanes so the
//               sync-following bytes of all active lanes leave together.
// Revision    : 1.0 - initial release
// ============================================================================
module mipi_rx_lane_deskew #(
  parameter int MAX_LANES = 4,
  parameter int MAX_SKEW  = 7,
  parameter int SW        = $clog2(MAX_SKEW + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [1:0]             lanes_cfg_i,
  input  logic [MAX_LANES-1:0]   bytes_valid_i,
  input  logic [8*MAX_LANES-1:0] byte_i,
  output logic                   lane_valid_o,
  output logic [8*MAX_LANES-1:0] lane_byte_o,
  output logic                   skew_error_o,
  output logic [SW-1:0]          skew_o
);

  localparam int DEPTH      = MAX_SKEW + 1;
  localparam int LOG2_LANES = $clog2(MAX_LANES);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_ALIGNED = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_ERROR   = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [SW-1:0]          cnt_q, cnt_d;
  logic [MAX_LANES-1:0]   mask_q, mask_d;
  logic [MAX_LANES-1:0]   arrived_q, arrived_d;
  logic [SW-1:0]          off_q   [MAX_LANES];
  logic [SW-1:0]          off_d   [MAX_LANES];
  logic [SW-1:0]          delay_q [MAX_LANES];
  logic [SW-1:0]          delay_d [MAX_LANES];
  logic [8:0]             hist_q  [MAX_LANES][DEPTH];
  logic [8:0]             hist_d  [MAX_LANES][DEPTH];
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic [8*MAX_LANES-1:0] bytes_q, bytes_d;
  logic [SW-1:0]          skew_q, skew_d;

  logic [MAX_LANES-1:0]   cfg_mask;
  logic [MAX_LANES-1:0]   act;
  logic [MAX_LANES-1:0]   in_act;
  logic                   dly_all;

  // Decode lane-count config into a lane mask; oversize values mean all lanes.
  always_comb begin
    cfg_mask = '0;
    for (int k = 0; k < MAX_LANES; k++) begin
      if (int'(lanes_cfg_i) >= LOG2_LANES) begin
        cfg_mask[k] = 1'b1;
      end else if (k < (1 << lanes_cfg_i)) begin
        cfg_mask[k] = 1'b1;
      end
    end
  end

  // The live config only matters while idle; otherwise the latched mask rules.
  assign act    = (state_q == S_IDLE) ? cfg_mask : mask_q;
  assign in_act = bytes_valid_i & act;

  // Per-lane history: entry 0 is the byte sampled on the current edge.
  always_comb begin
    for (int k = 0; k < MAX_LANES; k++) begin
      hist_d[k][0] = {bytes_valid_i[k], byte_i[8*k +: 8]};
      for (int i = 1; i < DEPTH; i++) begin
        hist_d[k][i] = hist_q[k][i-1];
      end
    end
  end

  // Alignment FSM: offset capture, delay freeze, deskewed output and burst end.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    arrived_d = arrived_q;
    off_d     = off_q;
    delay_d   = delay_q;
    skew_d    = skew_q;
    valid_d   = 1'b0;
    bytes_d   = '0;
    err_d     = 1'b0;
    dly_all   = 1'b1;
    case (state_q)
      S_IDLE: begin
        mask_d    = cfg_mask;
        cnt_d     = '0;
        arrived_d = '0;
        if (|in_act) begin
          arrived_d = in_act;
          for (int k = 0; k < MAX_LANES; k++) begin
            off_d[k] = '0;
          end
          if (in_act == act) begin
            // Every active lane arrived together: no delay needed.
            for (int k = 0; k < MAX_LANES; k++) begin
              delay_d[k] = '0;
            end
            skew_d  = '0;
            state_d = S_ALIGNED;
          end else begin
            cnt_d   = {{(SW-1){1'b0}}, 1'b1};
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        for (int k = 0; k < MAX_LANES; k++) begin
          if (in_act[k] && !arrived_q[k]) begin
            off_d[k] = cnt_q;
          end
        end
        // A lane that rose and fell again still counts as arrived.
        arrived_d = arrived_q | in_act;
        if ((arrived_d & act) == act) begin
          for (int k = 0; k < MAX_LANES; k++) begin
            delay_d[k] = cnt_q - off_d[k];
          end
          skew_d  = cnt_q;
          state_d = S_ALIGNED;
        end else if (int'(cnt_q) >= MAX_SKEW) begin
          err_d   = 1'b1;
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ALIGNED: begin
        for (int k = 0; k < MAX_LANES; k++) begin
          if (act[k] && !hist_q[k][delay_q[k]][8]) begin
            dly_all = 1'b0;
          end
        end
        if (dly_all) begin
          valid_d = 1'b1;
          for (int k = 0; k < MAX_LANES; k++) begin
            if (act[k]) begin
              bytes_d[8*k +: 8] = hist_q[k][delay_q[k]][7:0];
            end
          end
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN, S_ERROR: begin
        if (in_act == '0) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, history and registered outputs; asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      mask_q    <= '0;
      arrived_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      bytes_q   <= '0;
      skew_q    <= '0;
      for (int k = 0; k < MAX_LANES; k++) begin
        off_q[k]   <= '0;
        delay_q[k] <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          hist_q[k][i] <= '0;
        end
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      arrived_q <= arrived_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      bytes_q   <= bytes_d;
      skew_q    <= skew_d;
      for (int k = 0; k < MAX_LANES; k++) begin
        off_q[k]   <= off_d[k];
        delay_q[k] <= delay_d[k];
        for (int i = 0; i < DEPTH; i++) begin
          hist_q[k][i] <= hist_d[k][i];
        end
      end
    end
  end

  assign lane_valid_o = valid_q;
  assign lane_byte_o  = bytes_q;
  assign skew_error_o = err_q;
  assign skew_o       = skew_q;

endmodule
`default_nettype wire

// File: tb/tb_mipi_rx_lane_deskew.sv
`default_nettype none
// ============================================================================
// Module      : tb_mipi_rx_lane_deskew
// Description : Self-checking bench for mipi_rx_lane_deskew. Bursts are
//               described per lane (offset, length, bytes); a burst-level
//               model predicts the aligned word stream, skew and errors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mipi_rx_lane_deskew;

  localparam int ML   = 4;
  localparam int MS   = 7;
  localparam int SW   = 3;
  localparam int MAXC = 64;

  logic            clk_i = 1'b0;
  logic            reset_n_i;
  logic [1:0]      lanes_cfg_i;
  logic [ML-1:0]   bytes_valid_i;
  logic [8*ML-1:0] byte_i;
  logic            lane_valid_o;
  logic [8*ML-1:0] lane_byte_o;
  logic            skew_error_o;
  logic [SW-1:0]   skew_o;

  mipi_rx_lane_deskew #(.MAX_LANES(ML), .MAX_SKEW(MS)) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .lanes_cfg_i  (lanes_cfg_i),
    .bytes_valid_i(bytes_valid_i),
    .byte_i       (byte_i),
    .lane_valid_o (lane_valid_o),
    .lane_byte_o  (lane_byte_o),
    .skew_error_o (skew_error_o),
    .skew_o       (skew_o)
  );

  always #5 clk_i = ~clk_i;

  // Burst description
  int         b_cfg;
  int         b_off [ML];
  int         b_len [ML];
  logic [7:0] b_dat [ML][MAXC];
  bit         b_junk;
  bit         b_flip;
  int         b_maxend;
  int         n_cyc;

  // Observations and expectations
  logic            obs_v [MAXC];
  logic [8*ML-1:0] obs_b [MAXC];
  int              obs_err;
  logic [SW-1:0]   obs_skew;
  logic            exp_v [MAXC];
  logic [8*ML-1:0] exp_b [MAXC];
  int              exp_err;
  logic [SW-1:0]   exp_skew;
  int              m_skew;

  int total = 0;
  int bad   = 0;

  function automatic int nl_of(input int cfg);
    return (cfg >= 2) ? ML : (1 << cfg);
  endfunction

  task automatic set_burst(input int cfg, input int o0, input int o1, input int o2, input int o3,
                           input int l0, input int l1, input int l2, input int l3, input bit rnd);
    b_cfg = cfg;
    b_off[0] = o0; b_off[1] = o1; b_off[2] = o2; b_off[3] = o3;
    b_len[0] = l0; b_len[1] = l1; b_len[2] = l2; b_len[3] = l3;
    b_junk = 1'b0;
    b_flip = 1'b0;
    for (int k = 0; k < ML; k++) begin
      for (int i = 0; i < MAXC; i++) begin
        if (rnd) b_dat[k][i] = 8'($urandom);
        else     b_dat[k][i] = (i == 0) ? 8'hB8 : 8'(8'h10 + i - 1);
      end
    end
  endtask

  // Burst-level reference: spread = latest active arrival (earliest is 0),
  // word count = shortest active lane, first word one cycle after last arrival.
  task automatic model_burst();
    int nl, mx, mn, c;
    bit err;
    nl = nl_of(b_cfg);
    mx = 0; mn = MAXC; err = 1'b0; b_maxend = 0;
    for (int k = 0; k < nl; k++) begin
      if (b_len[k] == 0) err = 1'b1;
      else begin
        if (b_off[k] > mx) mx = b_off[k];
        if (b_len[k] < mn) mn = b_len[k];
        if (b_off[k] + b_len[k] > b_maxend) b_maxend = b_off[k] + b_len[k];
      end
    end
    if (mx > MS) err = 1'b1;
    n_cyc = ((b_maxend > MS + 2) ? b_maxend : MS + 2) + 4;
    for (int i = 0; i < MAXC; i++) begin
      exp_v[i] = 1'b0;
      exp_b[i] = '0;
    end
    exp_err = err ? 1 : 0;
    if (!err) begin
      m_skew = mx;
      for (int i = 0; i < mn; i++) begin
        c = mx + 1 + i;
        exp_v[c] = 1'b1;
        for (int k = 0; k < nl; k++) exp_b[c][8*k +: 8] = b_dat[k][i];
      end
    end
    exp_skew = SW'(m_skew);
  endtask

  // Drives one burst and records what the DUT produced (no judging here).
  task automatic drive_burst();
    logic [ML-1:0]   v;
    logic [8*ML-1:0] d;
    int nl;
    nl = nl_of(b_cfg);
    obs_err = 0;
    for (int c = 0; c < n_cyc; c++) begin
      v = '0;
      d = '0;
      for (int k = 0; k < ML; k++) begin
        if (k < nl) begin
          if (c >= b_off[k] && c < b_off[k] + b_len[k]) begin
            v[k] = 1'b1;
            d[8*k +: 8] = b_dat[k][c - b_off[k]];
          end else begin
            d[8*k +: 8] = 8'($urandom);
          end
        end else if (b_junk && c < b_maxend) begin
          v[k] = 1'($urandom);
          d[8*k +: 8] = 8'($urandom);
        end
      end
      if (b_flip && c >= 1 && c < b_maxend) lanes_cfg_i = (b_cfg < 2) ? 2'd3 : 2'd0;
      else                                  lanes_cfg_i = 2'(b_cfg);
      bytes_valid_i = v;
      byte_i        = d;
      @(posedge clk_i);
      #1;
      obs_v[c] = lane_valid_o;
      obs_b[c] = lane_byte_o;
      if (skew_error_o === 1'b1) obs_err++;
    end
    obs_skew = skew_o;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0; lanes_cfg_i = 2'd2; bytes_valid_i = '0; byte_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    total++; if (lane_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", lane_valid_o); end
    total++; if (lane_byte_o !== '0) begin bad++; $display("FAIL reset_bytes got=%h exp=0", lane_byte_o); end
    total++; if (skew_error_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", skew_error_o); end
    total++; if (skew_o !== '0) begin bad++; $display("FAIL reset_skew got=%0d exp=0", skew_o); end
    @(negedge clk_i);
    reset_n_i = 1'b1;
    m_skew = 0;
    @(posedge clk_i);
    #1;
    total++; if (lane_valid_o !== 1'b0 || skew_error_o !== 1'b0) begin bad++; $display("FAIL idle_after_reset got v=%b e=%b exp 0 0", lane_valid_o, skew_error_o); end
  endtask

  task automatic test_same_cycle();
    set_burst(2, 0, 0, 0, 0, 6, 6, 6, 6, 1'b0);
    model_burst();
    drive_burst();
    total++; if (obs_v[1] !== 1'b1 || obs_b[1] !== 32'hB8B8B8B8) begin bad++; $display("FAIL same_first got v=%b b=%h exp v=1 b=b8b8b8b8", obs_v[1], obs_b[1]); end
    for (int c = 0; c < n_cyc; c++) begin
      total++;
      if (obs_v[c] !== exp_v[c] || (exp_v[c] && obs_b[c] !== exp_b[c])) begin
        bad++; $display("FAIL same_word c=%0d got v=%b b=%h exp v=%b b=%h", c, obs_v[c], obs_b[c], exp_v[c], exp_b[c]);
      end
    end
    total++; if (obs_skew !== exp_skew) begin bad++; $display("FAIL same_skew got=%0d exp=%0d", obs_skew, exp_skew); end
    total++; if (obs_err !== exp_err) begin bad++; $display("FAIL same_err got=%0d exp=%0d", obs_err, exp_err); end
  endtask

  task automatic test_offsets();
    set_burst(2, 0, 3, 1, 2, 8, 8, 8, 8, 1'b0);
    model_burst();
    drive_burst();
    total++; if (obs_v[4] !== 1'b1 || obs_b[4] !== 32'hB8B8B8B8) begin bad++; $display("FAIL offs_first got v=%b b=%h exp v=1 b=b8b8b8b8", obs_v[4], obs_b[4]); end
    for (int c = 0; c < n_cyc; c++) begin
      total++;
      if (obs_v[c] !== exp_v[c] || (exp_v[c] && obs_b[c] !== exp_b[c])) begin
        bad++; $display("FAIL offs_word c=%0d got v=%b b=%h exp v=%b b=%h", c, obs_v[c], obs_b[c], exp_v[c], exp_b[c]);
      end
    end
    total++; if (obs_skew !== 3'd3) begin bad++; $display("FAIL offs_skew got=%0d exp=3", obs_skew); end
    total++; if (obs_err !== 0) begin bad++; $display("FAIL offs_err got=%0d exp=0", obs_err); end
  endtask

  // Spread MAX_SKEW aligns; MAX_SKEW+1 and a lane that never rises are errors.
  task automatic test_skew_limit();
    for (int s = 0; s < 3; s++) begin
      if (s == 0)      set_burst(2, 0, 7, 3, 5, 10, 10, 10, 10, 1'b1);
      else if (s == 1) set_burst(2, 0, 8, 2, 4, 12, 12, 12, 12, 1'b1);
      else             set_burst(2, 0, 1, 0, 2, 12, 12, 0, 12, 1'b1);
      model_burst();
      drive_burst();
      for (int c = 0; c < n_cyc; c++) begin
        total++;
        if (obs_v[c] !== exp_v[c] || (exp_v[c] && obs_b[c] !== exp_b[c])) begin
          bad++; $display("FAIL limit%0d_word c=%0d got v=%b b=%h exp v=%b b=%h", s, c, obs_v[c], obs_b[c], exp_v[c], exp_b[c]);
        end
      end
      total++; if (obs_skew !== exp_skew) begin bad++; $display("FAIL limit%0d_skew got=%0d exp=%0d", s, obs_skew, exp_skew); end
      total++; if (obs_err !== exp_err) begin bad++; $display("FAIL limit%0d_err got=%0d exp=%0d", s, obs_err, exp_err); end
    end
  endtask

  // 2-lane mode, first with idle upper lanes, then with garbage and a cfg flip.
  task automatic test_two_lane();
    for (int s = 0; s < 2; s++) begin
      set_burst(1, 0, 2, 0, 0, 7, 7, 7, 7, 1'b0);
      b_junk = (s == 1);
      b_flip = (s == 1);
      model_burst();
      drive_burst();
      for (int c = 0; c < n_cyc; c++) begin
        total++;
        if (obs_v[c] !== exp_v[c] || (exp_v[c] && obs_b[c] !== exp_b[c])) begin
          bad++; $display("FAIL two%0d_word c=%0d got v=%b b=%h exp v=%b b=%h", s, c, obs_v[c], obs_b[c], exp_v[c], exp_b[c]);
        end
      end
      total++; if (obs_b[3][31:16] !== 16'h0000) begin bad++; $display("FAIL two%0d_upper got=%h exp=0000", s, obs_b[3][31:16]); end
      total++; if (obs_skew !== 3'd2) begin bad++; $display("FAIL two%0d_skew got=%0d exp=2", s, obs_skew); end
    end
  endtask

  // Lanes of unequal length, followed by a fresh burst that must realign.
  task automatic test_unequal();
    for (int s = 0; s < 2; s++) begin
      if (s == 0) set_burst(2, 1, 0, 2, 1, 6, 6, 5, 6, 1'b1);
      else        set_burst(2, 2, 0, 1, 3, 6, 6, 6, 6, 1'b1);
      model_burst();
      drive_burst();
      for (int c = 0; c < n_cyc; c++) begin
        total++;
        if (obs_v[c] !== exp_v[c] || (exp_v[c] && obs_b[c] !== exp_b[c])) begin
          bad++; $display("FAIL uneq%0d_word c=%0d got v=%b b=%h exp v=%b b=%h", s, c, obs_v[c], obs_b[c], exp_v[c], exp_b[c]);
        end
      end
      total++; if (obs_skew !== exp_skew) begin bad++; $display("FAIL uneq%0d_skew got=%0d exp=%0d", s, obs_skew, exp_skew); end
    end
  endtask

  task automatic test_reset_mid();
    logic [8*ML-1:0] d;
    lanes_cfg_i = 2'd2;
    for (int c = 0; c < 4; c++) begin
      d = '0;
      for (int k = 0; k < ML; k++) d[8*k +: 8] = 8'($urandom);
      bytes_valid_i = (c == 0) ? 4'b1101 : 4'b1111;
      byte_i = d;
      @(posedge clk_i);
      #1;
    end
    total++; if (lane_valid_o !== 1'b1 || skew_o !== 3'd1) begin bad++; $display("FAIL mid_pre got v=%b skew=%0d exp v=1 skew=1", lane_valid_o, skew_o); end
    #2 reset_n_i = 1'b0;
    #1;
    total++; if (lane_valid_o !== 1'b0 || lane_byte_o !== '0 || skew_o !== '0 || skew_error_o !== 1'b0) begin
      bad++; $display("FAIL mid_async got v=%b b=%h skew=%0d e=%b exp all 0", lane_valid_o, lane_byte_o, skew_o, skew_error_o);
    end
    bytes_valid_i = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    m_skew = 0;
    set_burst(2, 0, 2, 2, 1, 7, 7, 7, 7, 1'b1);
    model_burst();
    drive_burst();
    for (int c = 0; c < n_cyc; c++) begin
      total++;
      if (obs_v[c] !== exp_v[c] || (exp_v[c] && obs_b[c] !== exp_b[c])) begin
        bad++; $display("FAIL mid_word c=%0d got v=%b b=%h exp v=%b b=%h", c, obs_v[c], obs_b[c], exp_v[c], exp_b[c]);
      end
    end
    total++; if (obs_skew !== exp_skew) begin bad++; $display("FAIL mid_skew got=%0d exp=%0d", obs_skew, exp_skew); end
  endtask

  task automatic test_random();
    int nl, z, e;
    for (int n = 0; n < 24; n++) begin
      set_burst(int'($urandom_range(0, 3)), 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
      nl = nl_of(b_cfg);
      for (int k = 0; k < ML; k++) begin
        b_off[k] = int'($urandom_range(0, MS));
        b_len[k] = int'($urandom_range(1, 12));
      end
      z = int'($urandom_range(0, nl - 1));
      b_off[z] = 0;
      if (nl > 1 && $urandom_range(0, 5) == 0) begin
        e = (z + 1) % nl;
        b_off[e] = MS + 1;
      end
      b_junk = 1'($urandom);
      b_flip = 1'($urandom);
      model_burst();
      drive_burst();
      for (int c = 0; c < n_cyc; c++) begin
        total++;
        if (obs_v[c] !== exp_v[c] || (exp_v[c] && obs_b[c] !== exp_b[c])) begin
          bad++; $display("FAIL rand%0d_word c=%0d got v=%b b=%h exp v=%b b=%h", n, c, obs_v[c], obs_b[c], exp_v[c], exp_b[c]);
        end
      end
      total++; if (obs_skew !== exp_skew) begin bad++; $display("FAIL rand%0d_skew got=%0d exp=%0d", n, obs_skew, exp_skew); end
      total++; if (obs_err !== exp_err) begin bad++; $display("FAIL rand%0d_err got=%0d exp=%0d", n, obs_err, exp_err); end
    end
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_offsets();
    test_skew_limit();
    test_two_lane();
    test_unequal();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
